mem_arbiter: RTL and testbench

- Sits between the three memory clients (SPART, CPU, audio) and the SDRAM memory controller's 32-bit word port.
- Takes per-client request/acknowledge transactions and grants the single controller port round-robin.
- Sequences each transaction: issue op, wait for busy, wait for completion, return read data.
- Adds an issue timeout so a lost command cannot hang a client.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, controller
// op encodings and client index assignments.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam int REQ_SPART = 0;
  localparam int REQ_CPU   = 1;
  localparam int REQ_AUDIO = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i,
// searching upward with wrap-around.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any_o && req_i[(int'(ptr_i) + off) % N]) begin
        any_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + off) % N);
        gnt_o[(int'(ptr_i) + off) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the SDRAM controller word port to SPART, CPU
// and audio; sequences issue/busy/completion with an issue timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                mc_op,
  output logic [ADDR_W-1:0]         mc_addr,
  output logic [DATA_W-1:0]         mc_wdata,
  input  logic [1:0]                mc_busy,
  input  logic [DATA_W-1:0]         mc_rdata,
  output state_t                    dbg_state,
  output logic [IDX_W-1:0]          dbg_rr_ptr
);

  // Handshake: a client holds req (with stable we/addr/wdata) until it sees its
  // one-cycle ack; req still high on the edge after ack counts as a new request.

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               we_q, we_d;
  logic               tout_q, tout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         op_q, op_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  mwdata_q, mwdata_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               busy;
  logic               timeout_hit;
  logic               grant;

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign busy        = (mc_busy != 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  // Foreign controller traffic seen in IDLE holds off a new grant.
  assign grant       = pick_any && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE: begin
        if (busy)             state_d = WAIT;
        else if (timeout_hit) state_d = DONE;
      end
      WAIT:    if (!busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    tout_d   = tout_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    op_d     = op_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        op_d = OP_NONE;
        if (grant) begin
          owner_d  = pick_idx;
          we_d     = |(we & pick_gnt);
          maddr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          mwdata_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
          op_d     = (|(we & pick_gnt)) ? OP_WRITE : OP_READ;
          tout_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      ISSUE: begin
        if (busy) begin
          op_d = OP_NONE;
        end else if (timeout_hit) begin
          op_d   = OP_NONE;
          tout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: op_d = OP_NONE;
      DONE: begin
        ack_d[owner_q] = 1'b1;
        if (tout_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (!we_q) begin
          rdata_d = mc_rdata;
        end
        rr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: op_d = OP_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      op_q     <= OP_NONE;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      op_q     <= op_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign mc_op      = op_q;
  assign mc_addr    = maddr_q;
  assign mc_wdata   = mwdata_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed client transactions against a small SDRAM
// controller model, checked through issue/ack expectation queues.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req, we, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic            err;
  logic [DW-1:0]   rdata, mc_wdata, mc_rdata;
  logic [AW-1:0]   mc_addr;
  logic [1:0]      mc_op, mc_busy, foreign_busy;
  logic            model_busy;
  state_t          dbg_state;
  logic [1:0]      dbg_rr_ptr;

  assign mc_busy = {1'b0, model_busy} | foreign_busy;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .mc_op(mc_op), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_busy(mc_busy), .mc_rdata(mc_rdata),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- controller model ----------------
  logic        busy_en;
  int          busy_len;
  int          mcnt;
  logic [1:0]  m_op;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] mem [logic [31:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      mcnt       <= 0;
      mc_rdata   <= '0;
    end else if (model_busy) begin
      if (mcnt <= 1) begin
        model_busy <= 1'b0;
        if (m_op == OP_WRITE) mem[m_addr] = m_wdata;
        else mc_rdata <= mem.exists(m_addr) ? mem[m_addr] : 32'h0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (busy_en && mc_op != OP_NONE) begin
      model_busy <= 1'b1;
      mcnt       <= busy_len;
      m_op       <= mc_op;
      m_addr     <= mc_addr;
      m_wdata    <= mc_wdata;
    end
  end

  // ---------------- clients drop req when acked ----------------
  int req_cnt [N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ack[i] && req_cnt[i] > 0) begin
        req_cnt[i] = req_cnt[i] - 1;
        if (req_cnt[i] == 0) req[i] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [65:0] exp_iss_q[$];
  logic [35:0] exp_ack_q[$];
  logic [65:0] ie;
  logic [35:0] ae;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [1:0]    prev_op = 2'b00;

  always @(negedge clk) begin
    if (!rst) begin
      if (mc_op != OP_NONE && prev_op == OP_NONE) begin
        checks++;
        if (exp_iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected got op=%b addr=%h wdata=%h want none", mc_op, mc_addr, mc_wdata);
        end else begin
          ie = exp_iss_q.pop_front();
          cur_addr  = ie[63:32];
          cur_wdata = ie[31:0];
          if ({mc_op, mc_addr, mc_wdata} !== ie) begin
            errors++;
            $display("FAIL issue got op=%b addr=%h wdata=%h want op=%b addr=%h wdata=%h",
                     mc_op, mc_addr, mc_wdata, ie[65:64], ie[63:32], ie[31:0]);
          end
        end
      end
      if (dbg_state == WAIT) begin
        checks++;
        if (mc_op !== OP_NONE || mc_addr !== cur_addr || mc_wdata !== cur_wdata) begin
          errors++;
          $display("FAIL wait_hold got op=%b addr=%h wdata=%h want op=00 addr=%h wdata=%h",
                   mc_op, mc_addr, mc_wdata, cur_addr, cur_wdata);
        end
      end
      if (ack != '0) begin
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected got ack=%b err=%b rdata=%h want none", ack, err, rdata);
        end else begin
          ae = exp_ack_q.pop_front();
          if ({ack, err, rdata} !== ae) begin
            errors++;
            $display("FAIL ack got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                     ack, err, rdata, ae[35:33], ae[32], ae[31:0]);
          end
        end
      end else if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_without_ack got err=%b want 0", err);
      end
    end
    prev_op = mc_op;
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push_iss(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    exp_iss_q.push_back({op, a, d});
  endtask

  task automatic push_ack(input logic [2:0] a, input logic e, input logic [31:0] d);
    exp_ack_q.push_back({a, e, d});
  endtask

  task automatic raise(input int c, input logic w, input logic [31:0] a, input logic [31:0] d, input int times);
    we[c] = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
    req_cnt[c] = times;
    req[c] = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(req == '0 && dbg_state == IDLE && ack == '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout got state=%0d req=%b want idle", name, dbg_state, req);
    end
  endtask

  task automatic wait_state(input state_t s, input string name);
    int n = 0;
    while (dbg_state != s && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout got state=%0d want %0d", name, dbg_state, s);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    busy_en = 1'b1; busy_len = 3; foreign_busy = 2'b00;
    for (int i = 0; i < N; i++) req_cnt[i] = 0;
    mem[32'h10]  = 32'h11111111;
    mem[32'h20]  = 32'h22222222;
    mem[32'h30]  = 32'h33333333;
    mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);

    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_mc_op", 64'(mc_op), 64'h0);
    chk("rst_mc_addr", 64'(mc_addr), 64'h0);
    chk("rst_mc_wdata", 64'(mc_wdata), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_rr", 64'(dbg_rr_ptr), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // all three request together from pointer 0; SPART asks twice
    push_iss(OP_READ, 32'h10, 32'hAAAA0000); push_ack(3'b001, 1'b0, 32'h11111111);
    push_iss(OP_READ, 32'h20, 32'hBBBB0000); push_ack(3'b010, 1'b0, 32'h22222222);
    push_iss(OP_READ, 32'h30, 32'hCCCC0000); push_ack(3'b100, 1'b0, 32'h33333333);
    push_iss(OP_READ, 32'h10, 32'hAAAA0000); push_ack(3'b001, 1'b0, 32'h11111111);
    raise(0, 1'b0, 32'h10, 32'hAAAA0000, 2);
    raise(1, 1'b0, 32'h20, 32'hBBBB0000, 1);
    raise(2, 1'b0, 32'h30, 32'hCCCC0000, 1);
    wait_idle("rr_all");
    chk("rr_after_all", 64'(dbg_rr_ptr), 64'h1);

    // single CPU read, busy 3 cycles: ack on the 7th cycle
    push_iss(OP_READ, 32'h100, 32'hBBBB0001); push_ack(3'b010, 1'b0, 32'hDEADBEEF);
    raise(1, 1'b0, 32'h100, 32'hBBBB0001, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < 50);
    chk("cpu_read_latency", 64'(n), 64'd7);
    wait_idle("cpu_read");
    chk("rr_after_cpu", 64'(dbg_rr_ptr), 64'h2);

    // audio write, then read back through the CPU
    busy_len = 4;
    push_iss(OP_WRITE, 32'h300, 32'h12345678); push_ack(3'b100, 1'b0, 32'hDEADBEEF);
    raise(2, 1'b1, 32'h300, 32'h12345678, 1);
    wait_idle("audio_write");
    push_iss(OP_READ, 32'h300, 32'h0); push_ack(3'b010, 1'b0, 32'h12345678);
    raise(1, 1'b0, 32'h300, 32'h0, 1);
    wait_idle("readback");

    // timeout: controller never goes busy
    busy_en = 1'b0;
    push_iss(OP_READ, 32'h40, 32'hAAAA0040); push_ack(3'b001, 1'b1, 32'h0);
    raise(0, 1'b0, 32'h40, 32'hAAAA0040, 1);
    n = 0;
    while (mc_op == OP_NONE && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (mc_op == OP_READ && n < 100) begin n++; @(negedge clk); end
    chk("timeout_issue_len", 64'(n), 64'(TO));
    wait_idle("timeout");
    busy_en = 1'b1;

    // reset in the middle of WAIT
    busy_len = 8;
    push_iss(OP_READ, 32'h100, 32'hBBBB0002);
    raise(1, 1'b0, 32'h100, 32'hBBBB0002, 1);
    wait_state(WAIT, "mid_wait");
    #2 rst = 1'b1;
    #1;
    chk("arst_mc_op", 64'(mc_op), 64'h0);
    chk("arst_mc_addr", 64'(mc_addr), 64'h0);
    chk("arst_ack", 64'(ack), 64'h0);
    chk("arst_state", 64'(dbg_state), 64'(IDLE));
    chk("arst_rr", 64'(dbg_rr_ptr), 64'h0);
    repeat (2) @(negedge clk);
    push_iss(OP_READ, 32'h100, 32'hBBBB0002); push_ack(3'b010, 1'b0, 32'hDEADBEEF);
    rst = 1'b0;
    wait_idle("regrant");

    // SPART drops req during WAIT; CPU asked during ISSUE
    busy_len = 5;
    push_iss(OP_READ, 32'h10, 32'hAAAA0010); push_ack(3'b001, 1'b0, 32'h11111111);
    push_iss(OP_READ, 32'h20, 32'hBBBB0020); push_ack(3'b010, 1'b0, 32'h22222222);
    raise(0, 1'b0, 32'h10, 32'hAAAA0010, 1);
    wait_state(ISSUE, "drop_issue");
    raise(1, 1'b0, 32'h20, 32'hBBBB0020, 1);
    wait_state(WAIT, "drop_wait");
    req[0] = 1'b0;
    wait_idle("drop");

    // foreign controller traffic holds off the grant
    foreign_busy = 2'b10;
    raise(2, 1'b0, 32'h30, 32'hCCCC0030, 1);
    repeat (5) @(negedge clk);
    chk("foreign_state", 64'(dbg_state), 64'(IDLE));
    chk("foreign_mc_op", 64'(mc_op), 64'h0);
    push_iss(OP_READ, 32'h30, 32'hCCCC0030); push_ack(3'b100, 1'b0, 32'h33333333);
    foreign_busy = 2'b00;
    wait_idle("foreign");

    repeat (3) @(negedge clk);
    chk("iss_queue_empty", 64'(exp_iss_q.size()), 64'h0);
    chk("ack_queue_empty", 64'(exp_ack_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time=%0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
